// File: rtl/adder_axi_pkg.sv
// adder_axi_pkg: register map, FSM states and AXI response codes for adder_axi_master
package adder_axi_pkg;
  localparam logic [7:0] REG_A = 8'h00;
  localparam logic [7:0] REG_B = 8'h04;
  localparam logic [7:0] REG_SUM = 8'h08;
  localparam logic [7:0] REG_OVF = 8'h0C;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  typedef enum logic [3:0] {
    IDLE, WR_A, WB_A, WR_B, WB_B, RA_SUM, RD_SUM, RA_OVF, RD_OVF, FIN
  } state_e;
  function automatic logic resp_err(input logic [1:0] r);
    return r != OKAY;
  endfunction
endpackage

// File: rtl/adder_axi_master.sv
// adder_axi_master: writes two operands to an AXI-Lite adder, reads back sum and overflow
module adder_axi_master
  import adder_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] b_q;
  logic err, phase, adv, tmo;
  // adv: the current phase completes at this edge; a write phase needs both AW and W done
  always_comb begin
    phase = state != IDLE && state != FIN;
    adv = (state == WR_A || state == WR_B) ?
            (!m1_axi_awvalid || m1_axi_awready) && (!m1_axi_wvalid || m1_axi_wready) :
          (state == WB_A || state == WB_B) ? m1_axi_bvalid :
          (state == RA_SUM || state == RA_OVF) ? m1_axi_arready :
          (state == RD_SUM || state == RD_OVF) ? m1_axi_rvalid : 1'b0;
    tmo = phase && !adv && cnt == CW'(TIMEOUT_CYCLES - 1);
  end
  assign busy = state != IDLE;
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state <= IDLE;
      cnt <= '0;
      b_q <= '0;
      err <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      m1_axi_awaddr <= '0;
      m1_axi_awvalid <= 1'b0;
      m1_axi_wdata <= '0;
      m1_axi_wstrb <= '0;
      m1_axi_wvalid <= 1'b0;
      m1_axi_bready <= 1'b0;
      m1_axi_araddr <= '0;
      m1_axi_arvalid <= 1'b0;
      m1_axi_rready <= 1'b0;
    end else begin
      cnt <= (adv || tmo || !phase) ? '0 : cnt + 1'b1;
      if (tmo) begin
        state <= FIN;
        m1_axi_awvalid <= 1'b0;
        m1_axi_wvalid <= 1'b0;
        m1_axi_bready <= 1'b0;
        m1_axi_arvalid <= 1'b0;
        m1_axi_rready <= 1'b0;
        err <= 1'b1;
        done <= 1'b1;
        error <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= WR_A;
            b_q <= op_b;
            m1_axi_awaddr <= ADDR_WIDTH'(REG_A);
            m1_axi_wdata <= op_a;
            m1_axi_wstrb <= '1;
            m1_axi_awvalid <= 1'b1;
            m1_axi_wvalid <= 1'b1;
          end
          WR_A, WR_B: begin
            if (m1_axi_awready) m1_axi_awvalid <= 1'b0;
            if (m1_axi_wready) m1_axi_wvalid <= 1'b0;
            if (adv) begin
              state <= state == WR_A ? WB_A : WB_B;
              m1_axi_bready <= 1'b1;
            end
          end
          WB_A, WB_B: if (m1_axi_bvalid) begin
            m1_axi_bready <= 1'b0;
            err <= err || resp_err(m1_axi_bresp);
            if (state == WB_A) begin
              state <= WR_B;
              m1_axi_awaddr <= ADDR_WIDTH'(REG_B);
              m1_axi_wdata <= b_q;
              m1_axi_awvalid <= 1'b1;
              m1_axi_wvalid <= 1'b1;
            end else begin
              state <= RA_SUM;
              m1_axi_araddr <= ADDR_WIDTH'(REG_SUM);
              m1_axi_arvalid <= 1'b1;
            end
          end
          RA_SUM, RA_OVF: if (m1_axi_arready) begin
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready <= 1'b1;
            state <= state == RA_SUM ? RD_SUM : RD_OVF;
          end
          RD_SUM: if (m1_axi_rvalid) begin
            m1_axi_rready <= 1'b0;
            result <= m1_axi_rdata;
            err <= err || resp_err(m1_axi_rresp);
            m1_axi_araddr <= ADDR_WIDTH'(REG_OVF);
            m1_axi_arvalid <= 1'b1;
            state <= RA_OVF;
          end
          RD_OVF: if (m1_axi_rvalid) begin
            m1_axi_rready <= 1'b0;
            overflow <= m1_axi_rdata[0];
            err <= err || resp_err(m1_axi_rresp);
            done <= 1'b1;
            error <= err || resp_err(m1_axi_rresp);
            state <= FIN;
          end
          FIN: begin
            done <= 1'b0;
            error <= 1'b0;
            err <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adder_axi_master.sv
// tb_adder_axi_master: directed and random sequences against a reactive adder slave
module tb_adder_axi_master;
  import adder_axi_pkg::*;
  localparam int DW = 32;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic start = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic busy, done, error, overflow;
  logic [DW-1:0] result, wdata;
  logic [DW/8-1:0] wstrb;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  adder_axi_master dut (
    .m1_axi_aclk(clk), .m1_axi_areset(areset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .error(error), .result(result), .overflow(overflow),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit ar_block = 1'b0;
  logic [1:0] bresp_b = 2'b00;
  logic [DW-1:0] regs [4];
  int wr_cnt [4] = '{default: 0};
  int ar_high = 0, aw_gap = 0, viol = 0;
  bit p_aw, p_w, p_b, p_ar, p_r, got_aw, got_w, got_ar, prev_awv, prev_wv, prev_arv;
  logic [AW-1:0] aw_a, ar_a, awaddr_s, araddr_s, prev_awaddr, prev_araddr;
  logic [DW-1:0] w_d, wdata_s, prev_wdata;
  logic [32:0] sum33;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  // Slave acts on negedges: applies last posedge's handshakes, then sets readies for the next one
  always @(negedge clk) begin
    if (areset) begin
      {awready, wready, bvalid, arready, rvalid} = '0;
      bresp = OKAY; rresp = OKAY; rdata = '0;
      {p_aw, p_w, p_b, p_ar, p_r, got_aw, got_w, got_ar, prev_awv, prev_wv, prev_arv} = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      for (int i = 0; i < 4; i++) regs[i] = '0;
    end else begin
      if (!done && prev_awv && !p_aw && (!awvalid || awaddr != prev_awaddr)) viol++;
      if (!done && prev_wv && !p_w && (!wvalid || wdata != prev_wdata)) viol++;
      if (!done && prev_arv && !p_ar && (!arvalid || araddr != prev_araddr)) viol++;
      if (p_aw) begin got_aw = 1'b1; aw_a = awaddr_s; end
      if (p_w) begin got_w = 1'b1; w_d = wdata_s; end
      if (p_ar) begin got_ar = 1'b1; ar_a = araddr_s; end
      if (p_b) bvalid = 1'b0;
      if (p_r) rvalid = 1'b0;
      if (got_aw && got_w && !bvalid) begin
        if (b_wait >= b_delay) begin
          regs[aw_a[3:2]] = w_d;
          wr_cnt[aw_a[3:2]]++;
          bresp = (aw_a == 8'h04) ? bresp_b : OKAY;
          bvalid = 1'b1; got_aw = 1'b0; got_w = 1'b0; b_wait = 0;
        end else b_wait++;
      end
      if (got_ar && !rvalid) begin
        if (r_wait >= r_delay) begin
          sum33 = {1'b0, regs[0]} + {1'b0, regs[1]};
          rdata = (ar_a == 8'h08) ? sum33[31:0] : (ar_a == 8'h0C) ? {31'b0, sum33[32]} : regs[ar_a[3:2]];
          rresp = OKAY; rvalid = 1'b1; got_ar = 1'b0; r_wait = 0;
        end else r_wait++;
      end
      awready = awvalid && aw_wait >= aw_delay;
      aw_wait = (awvalid && !awready) ? aw_wait + 1 : 0;
      wready = wvalid && w_wait >= w_delay;
      w_wait = (wvalid && !wready) ? w_wait + 1 : 0;
      arready = arvalid && !ar_block && ar_wait >= ar_delay;
      ar_wait = (arvalid && !arready) ? ar_wait + 1 : 0;
      if (!awvalid && wvalid) aw_gap++;
      if (arvalid) ar_high++;
      p_aw = awvalid && awready; awaddr_s = awaddr;
      p_w = wvalid && wready; wdata_s = wdata;
      p_ar = arvalid && arready; araddr_s = araddr;
      p_b = bvalid && bready;
      p_r = rvalid && rready;
      prev_awv = awvalid; prev_awaddr = awaddr;
      prev_wv = wvalid; prev_wdata = wdata;
      prev_arv = arvalid; prev_araddr = araddr;
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // lat counts negedges after start is accepted; done seen at lat 9 means FIN is the 9th cycle
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input int budget, input bit inj,
                     output int lat, output bit seen, output bit err_o, output bit done_after,
                     output bit busy_after);
    @(negedge clk); op_a = a; op_b = b; start = 1'b1;
    @(negedge clk); start = 1'b0; op_a = ~a; op_b = ~b; lat = 1;
    while (!done && lat < budget) begin
      @(negedge clk);
      start = inj && lat == 3;
      lat++;
    end
    start = 1'b0;
    seen = done; err_o = error;
    @(negedge clk); done_after = done; busy_after = busy;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, n, w0, w1, g0, ah;
    bit seen, e, da, ba, o_hold;
    logic [31:0] a, b, r_hold;
    logic [32:0] exp;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, error, overflow, awvalid, wvalid, bready, arvalid, rready, wstrb}, 0);
    check("reset_data", {result, wdata, awaddr, araddr}, 0);
    areset = 1'b0;
    w0 = wr_cnt[0]; w1 = wr_cnt[1];
    txn(32'd5, 32'd7, 400, 1'b0, lat, seen, e, da, ba);
    check("basic_done", seen, 1);
    check("basic_latency", lat, 9);
    check("basic_result", result, 12);
    check("basic_ovf", overflow, 0);
    check("basic_error", e, 0);
    check("basic_done_pulse", da, 0);
    check("basic_busy_after", ba, 0);
    check("basic_writes", {wr_cnt[0] - w0, wr_cnt[1] - w1}, {32'd1, 32'd1});
    txn(32'hFFFF_FFFF, 32'd1, 400, 1'b0, lat, seen, e, da, ba);
    check("carry_result", result, 0);
    check("carry_ovf", overflow, 1);
    w_delay = 3; w0 = wr_cnt[0]; w1 = wr_cnt[1]; g0 = aw_gap;
    txn(32'd100, 32'd23, 400, 1'b1, lat, seen, e, da, ba);
    check("wdly_latency", lat, 15);
    check("wdly_aw_early_drop", aw_gap - g0, 6);
    check("wdly_writes", {wr_cnt[0] - w0, wr_cnt[1] - w1}, {32'd1, 32'd1});
    check("wdly_result", {overflow, result}, 33'd123);
    w_delay = 0;
    bresp_b = SLVERR;
    txn(32'd10, 32'd20, 400, 1'b0, lat, seen, e, da, ba);
    check("bresp_done", seen, 1);
    check("bresp_error", e, 1);
    check("bresp_result", result, 30);
    bresp_b = DECERR;
    txn(32'd1, 32'd2, 400, 1'b0, lat, seen, e, da, ba);
    check("decerr_error", e, 1);
    bresp_b = OKAY;
    txn(32'd3, 32'd4, 400, 1'b0, lat, seen, e, da, ba);
    check("err_cleared", e, 0);
    ar_block = 1'b1; r_hold = result; o_hold = overflow; ah = ar_high;
    txn(32'd9, 32'd9, 600, 1'b0, lat, seen, e, da, ba);
    check("tmo_done", seen, 1);
    check("tmo_error", e, 1);
    check("tmo_latency", lat, 260);
    check("tmo_ar_cycles", ar_high - ah, 255);
    check("tmo_busy_after", ba, 0);
    check("tmo_hold", {o_hold, r_hold}, {overflow, result});
    ar_block = 1'b0;
    b_delay = 5;
    @(negedge clk); op_a = 32'd50; op_b = 32'd60; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    check("wba_reached", bready, 1);
    areset = 1'b1;
    #1;
    check("rst_mid_ctrl", {busy, done, error, overflow, awvalid, wvalid, bready, arvalid, rready, wstrb}, 0);
    check("rst_mid_data", {result, wdata, awaddr, araddr}, 0);
    @(negedge clk); @(negedge clk); areset = 1'b0; b_delay = 0;
    n = 0;
    repeat (30) begin @(negedge clk); if (done) n++; end
    check("rst_no_done", n, 0);
    check("rst_idle", busy, 0);
    for (int i = 0; i < 6; i++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      if (i == 0) begin a = 32'h8000_0001; b = 32'h8000_0002; end
      exp = {1'b0, a} + {1'b0, b};
      txn(a, b, 400, 1'b0, lat, seen, e, da, ba);
      check("rand_done", seen, 1);
      check("rand_result", {overflow, result}, exp);
      check("rand_error", e, 0);
    end
    check("handshake_stability", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
